// File: rtl/hc148_pkg.sv
// Shared types and constants for the 74HC148 event-capture block.
package hc148_pkg;

  localparam int unsigned KEY_W = 3;
  localparam int unsigned CNT_W = 8;

  // Encoder outputs are active-low.
  localparam logic             GS_ACTIVE = 1'b0;
  localparam logic             GS_IDLE   = 1'b1;
  localparam logic [KEY_W-1:0] CODE_IDLE = '1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    QUAL_PRESS   = 2'd1,
    HELD         = 2'd2,
    QUAL_RELEASE = 2'd3
  } state_e;

  function automatic logic [KEY_W-1:0] key_of(input logic [KEY_W-1:0] code_n);
    return ~code_n;
  endfunction

endpackage

// File: rtl/hc148_event_capture_fifo.sv
// Show-ahead event FIFO; a push while full without a pop is dropped and flagged.
module event_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 3,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout_c,
  output logic          full_c,
  output logic          empty_c,
  output logic          drop_c,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_en;
  logic          rd_en;

  assign full_c  = (count == (AW+1)'(DEPTH));
  assign empty_c = (count == '0);
  assign rd_en   = pop & ~empty_c;
  // When full, a simultaneous pop frees the slot the push reuses.
  assign wr_en   = push & (~full_c | rd_en);
  assign drop_c  = push & full_c & ~rd_en;
  assign dout_c  = empty_c ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

endmodule

// File: rtl/hc148_event_capture.sv
// Synchronises and debounces 74HC148 outputs, queuing one key-index event per press.
module hc148_event_capture
  import hc148_pkg::*;
#(
  parameter  int unsigned DEBOUNCE = 4,
  parameter  int unsigned DEPTH    = 4,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gs_n,
  input  logic [KEY_W-1:0] code_n,
  input  logic             ev_ready,
  input  logic             ovf_clr,
  output logic             ev_valid,
  output logic [KEY_W-1:0] ev_code,
  output logic [AW:0]      ev_count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE);

  logic             s1_gs_n, s_gs_n;
  logic [KEY_W-1:0] s1_code_n, s_code_n;
  logic [1:0]       fill;

  state_e           state, state_d;
  logic [KEY_W-1:0] cand, cand_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic             armed, armed_d;
  logic             push_c;

  logic             pop_c;
  logic             empty_c, full_c, drop_c;

  // Two-flop synchronisers; fill marks when stage two holds real samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_gs_n   <= GS_IDLE;
      s_gs_n    <= GS_IDLE;
      s1_code_n <= CODE_IDLE;
      s_code_n  <= CODE_IDLE;
      fill      <= 2'b00;
    end else begin
      s1_gs_n   <= gs_n;
      s_gs_n    <= s1_gs_n;
      s1_code_n <= code_n;
      s_code_n  <= s1_code_n;
      fill      <= {fill[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cand  <= CODE_IDLE;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_d;
      cand  <= cand_d;
      cnt   <= cnt_d;
      armed <= armed_d;
    end
  end

  assign cnt_inc = (cnt == DEB) ? cnt : cnt + 1'b1;

  // After reset the FSM stays disarmed until a debounced release is seen.
  always_comb begin
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    armed_d = armed;
    push_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!armed) begin
          if (!fill[1] || s_gs_n == GS_ACTIVE) begin
            cnt_d = '0;
          end else if (cnt == DEB) begin
            armed_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (s_gs_n == GS_ACTIVE) begin
          state_d = QUAL_PRESS;
          cand_d  = s_code_n;
          cnt_d   = CNT_W'(1);
        end
      end
      QUAL_PRESS: begin
        if (s_gs_n != GS_ACTIVE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s_code_n != cand) begin
          cand_d = s_code_n;
          cnt_d  = CNT_W'(1);
        end else if (cnt == DEB) begin
          push_c  = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (s_gs_n != GS_ACTIVE) begin
          state_d = QUAL_RELEASE;
          cnt_d   = CNT_W'(1);
        end else if (s_code_n != cand) begin
          state_d = QUAL_PRESS;
          cand_d  = s_code_n;
          cnt_d   = CNT_W'(1);
        end
      end
      QUAL_RELEASE: begin
        if (s_gs_n == GS_ACTIVE) begin
          if (s_code_n == cand) begin
            state_d = HELD;
          end else begin
            state_d = QUAL_PRESS;
            cand_d  = s_code_n;
            cnt_d   = CNT_W'(1);
          end
        end else if (cnt == DEB) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop_c    = ev_valid & ev_ready;
  assign ev_valid = ~empty_c;

  event_fifo #(.DEPTH(DEPTH), .W(KEY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .din     (key_of(cand)),
    .dout_c  (ev_code),
    .full_c  (full_c),
    .empty_c (empty_c),
    .drop_c  (drop_c),
    .count   (ev_count)
  );

  // A drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (drop_c)  ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_hc148_event_capture.sv
// Directed bench for hc148_event_capture with DEBOUNCE=4, DEPTH=4.
module tb_hc148_event_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       gs_n;
  logic [2:0] code_n;
  logic       ev_ready;
  logic       ovf_clr;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic [2:0] ev_count;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  hc148_event_capture #(.DEBOUNCE(4), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .gs_n     (gs_n),
    .code_n   (code_n),
    .ev_ready (ev_ready),
    .ovf_clr  (ovf_clr),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_count (ev_count),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [2:0] c);
    gs_n = 1'b0; code_n = c; step(10);
    gs_n = 1'b1; code_n = 3'b111; step(10);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1; step(1); ev_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] pat;

    // Reset with a key held
    rst = 1'b1; gs_n = 1'b0; code_n = 3'b000; ev_ready = 1'b0; ovf_clr = 1'b0;
    step(3);
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_count", 32'(ev_count), 32'd0);
    check("rst_ovf",   32'(ovf),      32'd0);
    check("rst_code",  32'(ev_code),  32'd0);
    rst = 1'b0;
    step(20);
    check("held_after_rst_valid", 32'(ev_valid), 32'd0);
    check("held_after_rst_count", 32'(ev_count), 32'd0);
    gs_n = 1'b1; code_n = 3'b111; step(10);

    // Clean press: latency 7 edges, key 5
    gs_n = 1'b0; code_n = 3'b010;
    n = 0;
    do begin step(1); n++; end while (!ev_valid && n < 20);
    check("clean_latency", 32'(n), 32'd7);
    check("clean_code",  32'(ev_code),  32'd5);
    check("clean_count", 32'(ev_count), 32'd1);
    step(13);
    check("clean_hold_count", 32'(ev_count), 32'd1);
    gs_n = 1'b1; code_n = 3'b111; step(10);
    check("clean_release_count", 32'(ev_count), 32'd1);
    pop_one();
    check("clean_pop_count", 32'(ev_count), 32'd0);
    check("clean_pop_valid", 32'(ev_valid), 32'd0);
    step(5);
    check("clean_no_second", 32'(ev_count), 32'd0);

    // Press bounce then stable key 1
    for (int i = 0; i < 6; i++) begin
      gs_n = i[0]; code_n = i[0] ? 3'b111 : 3'b110; step(2);
    end
    check("bounce_none_yet", 32'(ev_count), 32'd0);
    gs_n = 1'b0; code_n = 3'b110; step(20);
    check("bounce_count", 32'(ev_count), 32'd1);
    check("bounce_code",  32'(ev_code),  32'd1);
    // Release bounce with unchanged code
    pat = 8'b11011011;
    for (int i = 0; i < 8; i++) begin
      gs_n = pat[i]; code_n = pat[i] ? 3'b111 : 3'b110; step(1);
    end
    gs_n = 1'b1; code_n = 3'b111; step(10);
    check("rel_bounce_count", 32'(ev_count), 32'd1);
    pop_one();
    check("rel_bounce_empty", 32'(ev_count), 32'd0);

    // Priority escalation key 1 -> key 7
    gs_n = 1'b0; code_n = 3'b110; step(10);
    code_n = 3'b000; step(10);
    gs_n = 1'b1; code_n = 3'b111; step(10);
    check("esc_count", 32'(ev_count), 32'd2);
    check("esc_first", 32'(ev_code), 32'd1);
    pop_one();
    check("esc_second", 32'(ev_code), 32'd7);
    pop_one();
    check("esc_empty", 32'(ev_count), 32'd0);

    // Overflow: five events into four slots
    press(3'b000); press(3'b001); press(3'b010); press(3'b011); press(3'b100);
    check("ovf_count", 32'(ev_count), 32'd4);
    check("ovf_flag",  32'(ovf),      32'd1);
    check("ovf_pop0", 32'(ev_code), 32'd7); pop_one();
    check("ovf_pop1", 32'(ev_code), 32'd6); pop_one();
    check("ovf_pop2", 32'(ev_code), 32'd5); pop_one();
    check("ovf_pop3", 32'(ev_code), 32'd4); pop_one();
    check("ovf_drained", 32'(ev_count), 32'd0);
    check("ovf_sticky",  32'(ovf),      32'd1);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Full FIFO with push and pop on the same edge
    press(3'b101); press(3'b110); press(3'b111); press(3'b001);
    check("full_count", 32'(ev_count), 32'd4);
    check("full_ovf",   32'(ovf),      32'd0);
    gs_n = 1'b0; code_n = 3'b011; step(6);
    ev_ready = 1'b1; step(1); ev_ready = 1'b0;
    check("pp_count", 32'(ev_count), 32'd4);
    check("pp_ovf",   32'(ovf),      32'd0);
    gs_n = 1'b1; code_n = 3'b111; step(10);
    check("pp_e0", 32'(ev_code), 32'd1); pop_one();
    check("pp_e1", 32'(ev_code), 32'd0); pop_one();
    check("pp_e2", 32'(ev_code), 32'd6); pop_one();
    check("pp_e3", 32'(ev_code), 32'd4); pop_one();
    check("pp_empty", 32'(ev_valid), 32'd0);
    check("pp_ovf_end", 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hc148_event_capture.md
Name: hc148_event_capture

Overview:
- Downstream consumer of the 74HC148-style 8-to-3 priority encoder (outputs GS, dout, all active-low).
- Synchronises the encoder outputs, debounces them, and converts each qualified key press into a true-binary key-index event.
- Queues events in a small FIFO read by the control logic through a valid/ready handshake.
- Flags, with a sticky bit, any events lost to a full FIFO.

Parameters:
- DEBOUNCE, 4, consecutive synchronised cycles an input value must hold to qualify (legal 1..255).
- DEPTH, 4, FIFO entries (power of 2, legal 2..16).
- AW, $clog2(DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- gs_n  input  1  encoder group-select, low = some input active (asynchronous to clk)
- code_n  input  3  encoder dout, active-low code (asynchronous to clk)
- ev_ready  input  1  consumer accepts head event this cycle
- ovf_clr  input  1  clears sticky overflow flag
- ev_valid  output  1  FIFO non-empty; head event presented
- ev_code  output  3  head event key index, true binary (= ~code_n at qualification; 7 = highest priority)
- ev_count  output  AW+1  current FIFO occupancy, 0..DEPTH
- ovf  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (rst high at a clk edge):
  - Synchroniser flops load 1/111.
  - FSM goes to IDLE and the debounce counter clears.
  - FIFO is emptied.
  - ev_valid=0, ev_code=000, ev_count=0, ovf=0.
  - Reset mid-debounce or mid-hold discards all progress; no event is generated for a key still held after reset until it is released and re-pressed.
- Synchroniser: two flops each on gs_n and code_n. The FSM uses only the second stage (s_gs_n, s_code_n).
- FSM states:
  - IDLE: s_gs_n=0 -> QUAL_PRESS, cand <= s_code_n, cnt <= 1.
  - QUAL_PRESS:
    - s_gs_n=1 -> IDLE.
    - s_code_n != cand -> cand <= s_code_n, cnt <= 1.
    - Otherwise cnt++. When cnt reaches DEBOUNCE, push ~cand and go to HELD.
    - DEBOUNCE=1 pushes on the entry cycle's successor.
  - HELD:
    - s_gs_n=1 -> QUAL_RELEASE, cnt <= 1.
    - s_code_n != cand (higher-priority key added or key swapped) -> QUAL_PRESS with the new cand, cnt <= 1.
  - QUAL_RELEASE:
    - s_gs_n=0 and s_code_n == cand -> HELD (bounce, no new event).
    - s_gs_n=0 and s_code_n != cand -> QUAL_PRESS.
    - s_gs_n=1 -> cnt++. When cnt reaches DEBOUNCE -> IDLE.
- Latency:
  - A clean press held stable produces ev_valid=1 exactly DEBOUNCE+3 clk edges after the first edge that samples the new input value (2 sync + DEBOUNCE qualify + 1 push).
  - DEBOUNCE=4 gives 7 edges.
- FIFO (show-ahead):
  - ev_code always equals the head entry while ev_valid=1, and is held stable until popped.
  - Pop = ev_valid & ev_ready. Push = FSM qualify pulse.
  - Pointers wrap modulo DEPTH. ev_count = wptr-rptr held in AW+1 bits.
  - Simultaneous push and pop: both occur and ev_count is unchanged. This holds when full (slot freed by the pop is reused) and when empty is impossible (ev_valid=0 means no pop).
  - Push while full with no pop: the event is dropped, ovf <= 1, and FIFO contents are unchanged.
  - ev_ready with ev_valid=0 is ignored.
- ovf:
  - Set has priority over clear: if ovf_clr and a drop occur in the same cycle, ovf=1.
  - ovf_clr otherwise forces ovf=0 next edge.
- Codes are 3-bit modular; no arithmetic beyond counter increments. Saturate cnt at DEBOUNCE.

Decomposition:
- Shared package hc148_pkg holds:
  - FSM state typedef (IDLE, QUAL_PRESS, HELD, QUAL_RELEASE; 2-bit encoding).
  - KEY_W=3.
  - ACTIVE_LOW convention constants for encoder signals.
- One sub-module, event_fifo: parameterised DEPTH/width, show-ahead, push/pop/full/empty/count, drop-on-full reported to the parent.
- Synchroniser and FSM stay in the top module.

Test Plan:
- Reset: drive rst=1 for 3 edges with gs_n=0, code_n=000 -> ev_valid=0, ev_count=0, ovf=0. Release rst with the key still held -> no event until gs_n goes 1 for >=DEBOUNCE cycles and then 0 again.
- Clean press: gs_n=0, code_n=010 held 20 cycles (DEBOUNCE=4) -> ev_valid rises exactly 7 edges after first sample, ev_code=101, ev_count=1. Release for 10 cycles then ev_ready=1 one cycle -> ev_count=0, no second event.
- Bounce: toggle gs_n 0/1 every 2 cycles for 12 cycles, then hold 0 with code_n=110 -> exactly one event ev_code=001. Bounce on release (gs_n 1,1,0,1...) with code unchanged -> no extra event.
- Priority escalation: hold code_n=110 (key 1) qualified, then change to code_n=000 (key 7) with gs_n=0 for 6 cycles -> two events, in order 001 then 111.
- Overflow: ev_ready=0, generate 5 distinct press/release events with DEPTH=4 -> ev_count=4, ovf=1, FIFO pops 4 original codes in order. Assert ovf_clr -> ovf=0.
- Full push+pop: FIFO full, qualify a new press on the same cycle ev_ready=1 -> ev_count stays 4, ovf stays 0, new code appears as 4th entry.
